// File: rtl/regfile_dump_reader_pkg.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader_pkg
//
// Shared definitions for the register-file dump reader and the benches that
// drive it: FSM state encoding, default geometry of the CPU register file,
// and the stack-pointer reset value the register file comes out of reset with.
// ---------------------------------------------------------------------------
package regfile_dump_reader_pkg;

  // Default register-file geometry (RV32-style: 32 x 32-bit registers).
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

  // The register file resets x2 (sp) to the top of the scratch stack; every
  // other register resets to zero. Benches use these to build expected dumps.
  localparam logic [31:0] SP_RESET_VALUE = 32'h0000_2ffc;
  localparam int          SP_INDEX       = 2;

  // Dump walker states.
  //   IDLE  : waiting for start
  //   FETCH : rf_addr presents the current index, capture rf_data
  //   SEND  : beat offered on the dump stream until accepted
  //   DONE  : one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : regfile_dump_reader_pkg

// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
//
// Walks the CPU register file through its asynchronous read port and streams
// every word out on a valid/ready interface, tagged with its index, while
// accumulating a wrapping checksum of all accepted words. Used at halt time to
// feed dump/debug logic.
//
// Each register costs two cycles: FETCH captures rf_data for the index on
// rf_addr, SEND holds the beat until the consumer takes it. After the last
// beat is accepted, done pulses for one cycle and the walker returns to IDLE.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       one-cycle dump request, honoured only in IDLE
//   rf_addr     register index driven to the register-file async read port
//   rf_data     word returned combinationally for rf_addr
//   dump_valid  dump_idx/dump_data/dump_last carry a beat
//   dump_ready  consumer accepts the beat
//   dump_idx    register index of the current beat
//   dump_data   register contents of the current beat
//   dump_last   high with dump_valid on the final beat
//   busy        high from the cycle after start until done
//   done        one-cycle pulse after the last beat is accepted
//   checksum    sum of all accepted dump_data, mod 2^DATA_W
// ---------------------------------------------------------------------------
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit SKIP_X0  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  // First and last indices of the walk. x0 is hardwired to zero on the CPU,
  // so callers may drop it from the dump.
  localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_X0 ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx;

  logic              start_accept;  // start seen in IDLE
  logic              beat_accept;   // dump handshake in SEND

  // The register file is read asynchronously, so the index register itself
  // is the address; rf_data for it is ready to capture in FETCH.
  assign rf_addr = idx;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every flop is written with <= so all state updates on an edge see
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    start_accept = 1'b0;
    beat_accept  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = FETCH;
        end
      end

      FETCH: begin
        state_d = SEND;
      end

      SEND: begin
        if (dump_valid && dump_ready) begin
          beat_accept = 1'b1;
          state_d     = dump_last ? DONE : FETCH;
        end
      end

      // start is deliberately not looked at here: a request arriving while
      // the completion pulse is out is dropped, not queued.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: index counter, beat registers, checksum, status flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
    end else begin
      // Status flags are registered copies of where the FSM is going, so they
      // line up with the state they describe.
      busy <= (state_d == FETCH) || (state_d == SEND);
      done <= (state_d == DONE);

      if (start_accept) begin
        idx      <= FIRST_IDX;
        checksum <= '0;
      end

      if (state_q == FETCH) begin
        dump_data  <= rf_data;
        dump_idx   <= idx;
        dump_last  <= (idx == LAST_IDX);
        dump_valid <= 1'b1;
      end

      if (beat_accept) begin
        checksum   <= checksum + dump_data;
        dump_valid <= 1'b0;
        dump_last  <= 1'b0;
        // The index parks on the last register rather than wrapping.
        if (!dump_last) begin
          idx <= idx + ADDR_W'(1);
        end
      end
    end
  end

endmodule : regfile_dump_reader

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Sequential reader for the CPU register file's asynchronous read port. On a start pulse it walks register indices 0..NUM_REGS-1 and fetches each word. It streams each word out over a valid/ready interface, tagged with its index. It also accumulates a running checksum and pulses done at the end. It sits beside the register file at halt time, feeding testbench dump and debug logic, and is the consumer side of the register file's read interface.

Parameters:
NUM_REGS, 32, number of registers walked
ADDR_W, 5, register index width
DATA_W, 32, register word width
SKIP_X0, 0, when 1 the walk starts at index 1 (x0 omitted)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a dump; honoured only in IDLE
rf_addr  output  ADDR_W  index driven to the register-file async read port
rf_data  input  DATA_W  word returned combinationally for rf_addr
dump_valid  output  1  dump_idx/dump_data/dump_last hold a beat
dump_ready  input  1  downstream accepts the beat
dump_idx  output  ADDR_W  register index of the current beat
dump_data  output  DATA_W  register contents of the current beat
dump_last  output  1  high with dump_valid on the final beat
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after the last beat is accepted
checksum  output  DATA_W  sum of all accepted dump_data, mod 2^DATA_W

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset (reset low, any state, including mid-dump) forces:
  - state IDLE
  - every output to 0, including rf_addr, dump_*, busy, done and checksum
  - the index register to 0
- All outputs are registered. rf_addr is driven from the index register.
- States: IDLE, FETCH, SEND, DONE.
- IDLE: busy=0 and dump_valid=0. When start=1:
  - idx <= (SKIP_X0 ? 1 : 0)
  - checksum <= 0
  - go to FETCH
- FETCH (1 cycle): rf_addr=idx. On the clock edge:
  - dump_data <= rf_data, dump_idx <= idx
  - dump_last <= (idx == NUM_REGS-1)
  - dump_valid <= 1
  - go to SEND
- SEND: while dump_valid && !dump_ready, dump_idx, dump_data and dump_last hold stable; no unbounded-wait limit.
- SEND, on handshake (dump_valid && dump_ready):
  - checksum <= checksum + dump_data, wrapping
  - dump_valid <= 0
  - if the beat was last, go to DONE
  - otherwise idx <= idx+1 and go to FETCH
- DONE: done=1 for exactly one cycle, busy drops with it, then return to IDLE.
- Throughput: at most one beat per 2 cycles. Latency from start to first dump_valid is 2 cycles.
- start outside IDLE (including in DONE) is ignored; no queuing.
- checksum holds its final value from done until the next accepted start.
- idx never exceeds NUM_REGS-1; there is no wrap past the last register.
- Register writes landing during a dump are visible to any beat not yet fetched. Callers dump only when the CPU is halted.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FETCH, SEND, DONE)
  - NUM_REGS, ADDR_W and DATA_W defaults
  - stack-pointer reset constant 32'h2ffc and SP index 2, shared with benches
- No sub-module is needed. FSM, index counter and checksum accumulator stay in one module.

Test Plan:
- Register file freshly reset (x2=32'h2ffc, others 0); start pulse, dump_ready tied high:
  - 32 beats, dump_idx 0..31, idx 2 data 32'h2ffc, all others 0
  - dump_last only on idx 31, done one cycle after, checksum 32'h2ffc
- Backpressure: dump_ready low for 3 cycles while beat idx 5 is valid -> dump_idx/dump_data unchanged across those cycles, checksum is updated only once, and the sequence resumes at idx 6.
- SKIP_X0=1 with rf[i]=i for all i -> 31 beats, idx 1..31, checksum 32'd496.
- All registers 32'hFFFF_FFFF -> checksum 32'hFFFF_FFE0 (wrap-around); start asserted again at beat 10 is ignored.
- reset driven low asynchronously during SEND of idx 10 -> all outputs 0 immediately. After release, start gives a fresh dump from idx 0 with checksum restarted at 0.
